// File: rtl/nco_pkg.sv
// Shared types and constants for the multi-channel NCO.
package nco_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;

  // Table address is {line index, channel index}.
  function automatic int addr_w(input int vw, input int nch);
    return vw + $clog2(nch);
  endfunction

  function automatic int unity(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/nco_cmul.sv
// One W-bit complex rotation z*step with truncating shift.
// NCO_NCH_RENORM_EN adds a first-order gain correction with saturation.
module nco_cmul import nco_pkg::*; #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] s_i,
  input  logic signed [W-1:0] sc_i,
  input  logic signed [W-1:0] ss_i,
  output logic        [W-1:0] c_o,
  output logic        [W-1:0] s_o
);

  localparam int CW = 2 * W + 1;

  logic signed [CW-1:0] pc, ps;
  logic signed [W-1:0]  rc, rs;

  always_comb begin
    pc = CW'(c_i) * CW'(sc_i) - CW'(s_i) * CW'(ss_i);
    ps = CW'(s_i) * CW'(sc_i) + CW'(c_i) * CW'(ss_i);
    rc = W'(pc >>> (W - 1));
    rs = W'(ps >>> (W - 1));
  end

`ifdef NCO_NCH_RENORM_EN
  localparam logic signed [W+1:0]  THREE = (W+2)'(3 << (W - 1));
  localparam logic signed [CW-1:0] MAXV  = CW'(unity(W));
  localparam logic signed [CW-1:0] MINV  = -MAXV;

  logic signed [CW-1:0] mag, nc, ns;
  logic signed [W+1:0]  gd, g;

  function automatic logic [W-1:0] sat(input logic signed [CW-1:0] x);
    if (x > MAXV) return MAXV[W-1:0];
    if (x < MINV) return MINV[W-1:0];
    return x[W-1:0];
  endfunction

  // g = (3 - |z|^2)/2 pulls the magnitude back towards unity each step.
  always_comb begin
    mag = CW'(rc) * CW'(rc) + CW'(rs) * CW'(rs);
    gd  = THREE - (W+2)'(mag >>> (W - 1));
    g   = gd >>> 1;
    nc  = CW'(rc) * CW'(g);
    ns  = CW'(rs) * CW'(g);
    c_o = sat(nc >>> (W - 1));
    s_o = sat(ns >>> (W - 1));
  end
`else
  assign c_o = rc;
  assign s_o = rs;
`endif

endmodule

// File: rtl/nco_nch.sv
// NCH-channel rotating NCO: seeds and step fetched from a table per line.
// NCO_NCH_RENORM_EN enables per-step gain correction (valid latency 2).
module nco_nch import nco_pkg::*; #(
  parameter int NCH = 4,
  parameter int W   = 18,
  parameter int VW  = 9
) (
  input  logic                        CK,
  input  logic                        RST_N,
  input  logic                        START,
  input  logic [VW-1:0]               v_pos,
  input  logic                        ADV,
  output logic [addr_w(VW, NCH)-1:0]  rom_addr,
  input  logic [2*W-1:0]              rom_data,
  output logic                        ready,
  output logic                        valid,
  output logic [NCH*W-1:0]            cos_o,
  output logic [NCH*W-1:0]            sin_o
);

  localparam int IW = $clog2(NCH);
  localparam int AW = addr_w(VW, NCH);
  localparam logic [W-1:0] UNITY = W'(unity(W));
`ifdef NCO_NCH_RENORM_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [VW-1:0]           vpos_q, vpos_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [W-1:0]            sc_q, sc_d, ss_q, ss_d;
  logic [NCH-1:0][W-1:0]   c_q, c_d, s_q, s_d, rot_c, rot_s;
  logic                    adv_acc;
  logic [STAGES-1:0]       vld_q;
  logic [STAGES:0]         vld_pipe;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    nco_cmul #(.W(W)) u_cmul (
      .c_i (c_q[k]),
      .s_i (s_q[k]),
      .sc_i(sc_q),
      .ss_i(ss_q),
      .c_o (rot_c[k]),
      .s_o (rot_s[k])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vpos_d  = vpos_q;
    addr_d  = addr_q;
    sc_d    = sc_q;
    ss_d    = ss_q;
    c_d     = c_q;
    s_d     = s_q;
    adv_acc = 1'b0;
    if (START) begin
      // Abort whatever is in flight; a coincident ADV is dropped.
      state_d = FETCH;
      idx_d   = '0;
      vpos_d  = v_pos;
      addr_d  = {v_pos, {IW{1'b0}}};
      c_d[0]  = UNITY;
      s_d[0]  = '0;
    end else begin
      case (state_q)
        FETCH: begin
          // Data on rom_data belongs to the address issued last cycle (idx-1),
          // which seeds channel idx.
          if (idx_q != '0) begin
            c_d[idx_q] = rom_data[W-1:0];
            s_d[idx_q] = rom_data[2*W-1:W];
          end
          if (idx_q == IW'(NCH - 1)) begin
            state_d = LOAD;
          end else begin
            idx_d  = idx_q + IW'(1);
            addr_d = {vpos_q, idx_q + IW'(1)};
          end
        end
        LOAD: begin
          sc_d    = rom_data[W-1:0];
          ss_d    = rom_data[2*W-1:W];
          state_d = RUN;
        end
        RUN: begin
          if (ADV) begin
            adv_acc = 1'b1;
            c_d     = rot_c;
            s_d     = rot_s;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb vld_pipe = {vld_q, adv_acc};

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vpos_q  <= '0;
      addr_q  <= '0;
      sc_q    <= '0;
      ss_q    <= '0;
      c_q     <= '0;
      s_q     <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vpos_q  <= vpos_d;
      addr_q  <= addr_d;
      sc_q    <= sc_d;
      ss_q    <= ss_d;
      c_q     <= c_d;
      s_q     <= s_d;
      vld_q   <= vld_pipe[STAGES-1:0];
    end
  end

`ifdef NCO_NCH_RENORM_EN
  logic [NCH-1:0][W-1:0] oc_q, oc_d, os_q, os_d;

  // Output stage copies the rotated state one cycle later, and the seeds at LOAD.
  always_comb begin
    oc_d = oc_q;
    os_d = os_q;
    if (vld_pipe[1] || state_q == LOAD) begin
      oc_d = c_q;
      os_d = s_q;
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      oc_q <= '0;
      os_q <= '0;
    end else begin
      oc_q <= oc_d;
      os_q <= os_d;
    end
  end

  assign cos_o = oc_q;
  assign sin_o = os_q;
`else
  assign cos_o = c_q;
  assign sin_o = s_q;
`endif

  assign rom_addr = addr_q;
  assign ready    = (state_q == RUN);
  assign valid    = vld_pipe[STAGES];

endmodule

// File: tb/tb_nco_nch.sv
// Directed bench for nco_nch: table model, bit-exact rotation model, drift check.
// Expectations follow NCO_NCH_RENORM_EN when it is defined.
module tb_nco_nch;

  localparam int NCH = 4;
  localparam int W   = 18;
  localparam int VW  = 9;
  localparam int IW  = 2;
  localparam int AW  = VW + IW;
  localparam longint UNITY = 131071;
`ifdef NCO_NCH_RENORM_EN
  localparam int     LAT   = 2;
  localparam longint SIN90 = 131071;
`else
  localparam int     LAT   = 1;
  localparam longint SIN90 = 131070;
`endif

  logic            CK = 1'b0;
  logic            RST_N = 1'b0;
  logic            START = 1'b0;
  logic            ADV = 1'b0;
  logic [VW-1:0]   v_pos = '0;
  logic [AW-1:0]   rom_addr, addr_d1;
  logic [2*W-1:0]  rom_data;
  logic            ready, valid;
  logic [NCH*W-1:0] cos_o, sin_o;

  longint step_c = 0, step_s = 131071;
  longint mc[NCH], ms[NCH];
  int     n_vec = 0, n_miss = 0;

  nco_nch #(.NCH(NCH), .W(W), .VW(VW)) dut (
    .CK(CK), .RST_N(RST_N), .START(START), .v_pos(v_pos), .ADV(ADV),
    .rom_addr(rom_addr), .rom_data(rom_data), .ready(ready), .valid(valid),
    .cos_o(cos_o), .sin_o(sin_o)
  );

  always #5 CK = ~CK;

  // Table: seed words for idx < NCH-1, step word at idx NCH-1; one-cycle read latency.
  function automatic longint seed_c(input int a); return 1000 * (a + 1); endfunction
  function automatic longint seed_s(input int a); return -3 * (a + 1); endfunction

  always @(posedge CK) addr_d1 <= rom_addr;
  always_comb begin
    rom_data = '0;
    if (addr_d1[IW-1:0] == IW'(NCH - 1)) rom_data = {W'(step_s), W'(step_c)};
    else rom_data = {W'(seed_s(int'(addr_d1))), W'(seed_c(int'(addr_d1)))};
  end

  function automatic longint wrapw(input longint x);
    logic [W-1:0] t;
    t = x[W-1:0];
    return longint'($signed(t));
  endfunction

  function automatic longint satw(input longint x);
    if (x > UNITY) return UNITY;
    if (x < -UNITY) return -UNITY;
    return x;
  endfunction

  task automatic rot_model();
    longint c, s, nc, ns;
    for (int k = 0; k < NCH; k++) begin
      c  = mc[k];
      s  = ms[k];
      nc = wrapw((c * step_c - s * step_s) >>> (W - 1));
      ns = wrapw((s * step_c + c * step_s) >>> (W - 1));
`ifdef NCO_NCH_RENORM_EN
      begin
        longint mag, g;
        mag = (nc * nc + ns * ns) >>> (W - 1);
        g   = ((longint'(3) << (W - 1)) - mag) >>> 1;
        nc  = satw((nc * g) >>> (W - 1));
        ns  = satw((ns * g) >>> (W - 1));
      end
`endif
      mc[k] = nc;
      ms[k] = ns;
    end
  endtask

  task automatic chk(input string tag, input logic signed [127:0] got,
                     input logic signed [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] chan_c(input int k);
    return 64'($signed(cos_o[k*W +: W]));
  endfunction
  function automatic logic signed [63:0] chan_s(input int k);
    return 64'($signed(sin_o[k*W +: W]));
  endfunction

  task automatic cmp_all(input string tag);
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s_cos%0d", tag, k), chan_c(k), mc[k]);
      chk($sformatf("%s_sin%0d", tag, k), chan_s(k), ms[k]);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Pulse START (optionally with ADV held high), check addresses and latency.
  task automatic start_line(input int v, input bit adv_during);
    int lat;
    lat   = -1;
    v_pos = VW'(v);
    START = 1'b1;
    ADV   = adv_during;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      START = 1'b0;
      if (i <= 2) chk("start_valid", valid, 0);
      if (i == 2) ADV = 1'b0;
      if (i <= NCH) chk($sformatf("addr%0d", i - 1), rom_addr, v * NCH + i - 1);
      if (ready) lat = i;
    end
    chk("start_lat", lat, NCH + 2);
    mc[0] = UNITY;
    ms[0] = 0;
    for (int k = 1; k < NCH; k++) begin
      mc[k] = seed_c(v * NCH + k - 1);
      ms[k] = seed_s(v * NCH + k - 1);
    end
    chk("seed_ch0_cos", chan_c(0), UNITY);
    chk("seed_ch0_sin", chan_s(0), 0);
    cmp_all("seed");
    chk("addr_hold", rom_addr, v * NCH + NCH - 1);
  endtask

  task automatic burst(input int n, input bit each);
    bit ev;
    ADV = 1'b1;
    for (int j = 1; j <= n + LAT + 1; j++) begin
      tick();
      if (j == n) ADV = 1'b0;
      ev = (j >= LAT) && (j < LAT + n);
      chk("burst_valid", valid, ev);
      if (ev) begin
        rot_model();
        if (each) cmp_all("burst");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real cr, sr, m, d;
    int  ppm;

    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_cos", cos_o, 0);
    chk("rst_sin", sin_o, 0);
    RST_N = 1'b1;
    tick();
    tick();
    chk("idle_ready", ready, 0);

    // Line 5 with a +90 degree step.
    start_line(5, 1'b0);
    ADV = 1'b1;
    tick();
    ADV = 1'b0;
    repeat (LAT - 1) tick();
    chk("rot90_valid", valid, 1);
    chk("rot90_cos", chan_c(0), 0);
    chk("rot90_sin", chan_s(0), SIN90);
    rot_model();
    cmp_all("rot90");
    tick();
    chk("rot90_vdrop", valid, 0);
    cmp_all("rot90_hold");

    // ~1 degree step; restart while ADV is high, then an 8-cycle burst.
    step_c = 131051;
    step_s = 2287;
    start_line(7, 1'b1);
    burst(8, 1'b1);

    // 1000 steps from a fresh unity seed, then magnitude drift of channel 0.
    start_line(7, 1'b0);
    burst(1000, 1'b0);
    cmp_all("drift_exact");
    cr  = real'(chan_c(0));
    sr  = real'(chan_s(0));
    m   = $sqrt(cr * cr + sr * sr);
    d   = (m > 131071.0) ? m - 131071.0 : 131071.0 - m;
    ppm = int'(d / 131071.0 * 1.0e6);
`ifdef NCO_NCH_RENORM_EN
    chk("drift_on_small", ppm < 100, 1);
`else
    chk("drift_off_large", ppm > 5000, 1);
`endif

    // Asynchronous reset in the middle of RUN.
    ADV = 1'b1;
    tick();
    ADV = 1'b0;
    repeat (LAT - 1) tick();
    chk("prerst_valid", valid, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_valid", valid, 0);
    chk("arst_cos", cos_o, 0);
    chk("arst_sin", sin_o, 0);
    chk("arst_addr", rom_addr, 0);
    tick();
    RST_N = 1'b1;
    tick();
    tick();
    chk("postrst_ready", ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
